aes_round_ctrl: RTL
===================

Name: aes_round_ctrl

Overview:
Iterative AES-encryption sequencer. Accepts one 128-bit block per valid/ready handshake and triggers key expansion. Drives the shared SubBytes/ShiftRows/MixColumns/AddRoundKey round datapath once per cycle for rounds 0..Nr, holding the round state in its own register. Presents the ciphertext on a valid/ready output. Sits between the block-level wrapper and the combinational round datapath plus key-expansion unit.

Parameters:
MAX_NR, 14, largest supported round count; sets the rk_idx range.
KEY_TIMEOUT, 64, cycles to wait for kexp_done before flagging an error.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  plain_text/nk valid
in_ready  out  1  controller can accept a block
plain_text  in  128  input block
nk  in  4  key length in words: 4, 6 or 8
kexp_start  out  1  one-cycle pulse that starts key expansion
kexp_done  in  1  level; key schedule valid
kexp_err  in  1  level; key-expansion failure
dp_state  out  128  round-state register fed to the datapath
dp_bypass  out  1  round 0: AddRoundKey only
dp_final  out  1  last round: skip MixColumns
rk_idx  out  4  round-key index into the schedule
dp_result  in  128  combinational datapath output
out_valid  out  1  cipher_text/err valid
out_ready  in  1  consumer accepts the result
cipher_text  out  128  result block; 0 on error
err  out  1  result is an error
busy  out  1  not in IDLE

Behaviour:
- Reset (rst low, async): state IDLE; in_ready=1; every other output 0; internal state, round and timeout registers 0.
- Nr is decoded at accept: nk=4→10, nk=6→12, nk=8→14. Any other nk goes straight to OUT with err=1 and cipher_text=0.
- States:
  - IDLE → KEY when in_valid&&in_ready. Capture plain_text into the state register; capture nk and Nr.
  - KEY: kexp_start=1 only in the first KEY cycle. Timeout counter increments each cycle.
    - kexp_done=1 → ROUND, round=0.
    - kexp_err=1, or counter reaches KEY_TIMEOUT-1 without done → OUT with err=1. kexp_err has priority over kexp_done in the same cycle.
  - ROUND: rk_idx=round; dp_bypass=(round==0); dp_final=(round==Nr).
    - Each cycle: state register ← dp_result; round ← round+1.
    - When round==Nr: cipher_text ← dp_result, err ← 0, → OUT.
  - OUT: out_valid=1; cipher_text and err held stable until out_ready. On the out_valid&&out_ready cycle → IDLE, out_valid → 0 next cycle.
- in_ready=1 only in IDLE. No input accept in the same cycle as output handshake; one bubble minimum between blocks.
- Latency: if kexp_done is first sampled high at cycle D, round 0 executes at D+1, round Nr at D+1+Nr, and out_valid rises at D+2+Nr.
- Round counter is 4 bits and never exceeds Nr; no wrap.
- dp_state always equals the internal state register, including in OUT.
- Input changes outside the accept cycle are ignored.
- Reset asserted mid-operation aborts immediately; no partial result is emitted.

Optional Feature:
AES_DECRYPT_EN:
- Defined: adds input port decrypt (1 bit, captured at accept) and output dp_inv (= captured decrypt, held through ROUND). When decrypt=1, rk_idx counts Nr down to 0; dp_bypass is asserted at rk_idx==Nr, and dp_final at rk_idx==0.
- Undefined: neither port exists; encryption only, rk_idx ascending.

Decomposition:
- Package aes_ctrl_pkg:
  - state enum: IDLE, KEY, ROUND, OUT
  - NR_128=10, NR_192=12, NR_256=14
  - RK_IDX_W=4
  - nk→Nr decode function, with a legality flag
- One natural sub-module, aes_key_watchdog: timeout counter with start/clear/expire.
- Everything else stays in aes_round_ctrl.

Test Plan:
- FIPS-197 C.1: nk=4, pt 00112233445566778899aabbccddeeff, datapath+kexp bound → cipher 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly D+12; rk_idx sequence 0..10.
- nk=8, FIPS-197 C.3 vectors → cipher 8ea2b7ca516745bfeafc49904b496089; dp_final only at rk_idx 14; dp_bypass only at rk_idx 0.
- nk=5 → out_valid at accept+2, err=1, cipher_text=0; kexp_start never pulses.
- kexp_done held low → err=1 after KEY_TIMEOUT cycles; separately, kexp_err with kexp_done in the same cycle → err=1.
- out_ready held low 7 cycles → cipher_text/err stable, in_ready=0; release → IDLE next cycle, in_ready=1.
- rst low at ROUND round=5 → all outputs 0 asynchronously; next accepted block completes with a correct cipher.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
// Decrypt support in the sequencer is enabled with AES_DECRYPT_EN.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEY   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } ctrl_state_e;

  localparam int RK_IDX_W = 4;

  localparam logic [RK_IDX_W-1:0] NR_128 = 4'd10;
  localparam logic [RK_IDX_W-1:0] NR_192 = 4'd12;
  localparam logic [RK_IDX_W-1:0] NR_256 = 4'd14;

  typedef struct packed {
    logic                ok;
    logic [RK_IDX_W-1:0] nr;
  } nr_dec_t;

  // Key length in words -> round count; ok=0 for unsupported lengths.
  function automatic nr_dec_t nk_to_nr(input logic [3:0] nk);
    nr_dec_t d;
    d.ok = 1'b0;
    d.nr = '0;
    case (nk)
      4'd4: begin d.ok = 1'b1; d.nr = NR_128; end
      4'd6: begin d.ok = 1'b1; d.nr = NR_192; end
      4'd8: begin d.ok = 1'b1; d.nr = NR_256; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/aes_key_watchdog.sv
// Key-expansion timeout counter: cleared while not waiting, counts while run,
// flags expire on the TIMEOUT-th waiting cycle.
module aes_key_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    expire = run && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clear)             cnt_d = '0;
    else if (run && !expire) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: accept block, run key expansion, drive rounds 0..Nr.
// Optional AES_DECRYPT_EN adds decrypt/dp_inv and descending round-key order.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int MAX_NR      = 14,
  parameter int KEY_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        plain_text,
  input  logic [3:0]          nk,
`ifdef AES_DECRYPT_EN
  input  logic                decrypt,
  output logic                dp_inv,
`endif
  output logic                kexp_start,
  input  logic                kexp_done,
  input  logic                kexp_err,
  output logic [127:0]        dp_state,
  output logic                dp_bypass,
  output logic                dp_final,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        dp_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        cipher_text,
  output logic                err,
  output logic                busy
);

  ctrl_state_e         fsm_q, fsm_d;
  logic [127:0]        blk_q, blk_d;
  logic [127:0]        cipher_q, cipher_d;
  logic [RK_IDX_W-1:0] round_q, round_d;
  logic [RK_IDX_W-1:0] nr_q, nr_d;
  logic                nk_bad_q, nk_bad_d;
  logic                err_q, err_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                kexp_start_q, kexp_start_d;
  logic                dec_q, dec_d;

  nr_dec_t nk_dec;
  logic    nk_ok;
  logic    wd_expire;
  logic    in_round;

  assign nk_dec = nk_to_nr(nk);
  assign nk_ok  = nk_dec.ok && (int'(nk_dec.nr) <= MAX_NR);

  aes_key_watchdog #(
    .TIMEOUT (KEY_TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (fsm_q != KEY),
    .run    (fsm_q == KEY),
    .expire (wd_expire)
  );

  always_comb begin
    fsm_d        = fsm_q;
    blk_d        = blk_q;
    cipher_d     = cipher_q;
    round_d      = round_q;
    nr_d         = nr_q;
    nk_bad_d     = nk_bad_q;
    err_d        = err_q;
    dec_d        = dec_q;
    kexp_start_d = 1'b0;

    case (fsm_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          blk_d        = plain_text;
          nr_d         = nk_dec.nr;
          nk_bad_d     = !nk_ok;
          round_d      = '0;
          kexp_start_d = nk_ok;
`ifdef AES_DECRYPT_EN
          dec_d        = decrypt;
`endif
          fsm_d        = KEY;
        end
      end
      KEY: begin
        // An illegal key length passes through KEY without starting expansion.
        if (nk_bad_q || kexp_err) begin
          err_d    = 1'b1;
          cipher_d = '0;
          fsm_d    = OUT;
        end else if (kexp_done) begin
          round_d = '0;
          fsm_d   = ROUND;
        end else if (wd_expire) begin
          err_d    = 1'b1;
          cipher_d = '0;
          fsm_d    = OUT;
        end
      end
      ROUND: begin
        blk_d = dp_result;
        if (round_q == nr_q) begin
          cipher_d = dp_result;
          err_d    = 1'b0;
          round_d  = '0;
          fsm_d    = OUT;
        end else begin
          round_d = round_q + RK_IDX_W'(1);
        end
      end
      OUT: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase

    in_ready_d  = (fsm_d == IDLE);
    out_valid_d = (fsm_d == OUT);
    busy_d      = (fsm_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q        <= IDLE;
      blk_q        <= '0;
      cipher_q     <= '0;
      round_q      <= '0;
      nr_q         <= '0;
      nk_bad_q     <= 1'b0;
      err_q        <= 1'b0;
      dec_q        <= 1'b0;
      kexp_start_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      blk_q        <= blk_d;
      cipher_q     <= cipher_d;
      round_q      <= round_d;
      nr_q         <= nr_d;
      nk_bad_q     <= nk_bad_d;
      err_q        <= err_d;
      dec_q        <= dec_d;
      kexp_start_q <= kexp_start_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign in_round = (fsm_q == ROUND);

  // Bypass/final track the round position, so in decrypt they land on rk_idx Nr and 0.
  assign dp_bypass = in_round && (round_q == '0);
  assign dp_final  = in_round && (round_q == nr_q);
  assign rk_idx    = !in_round ? '0 : (dec_q ? (nr_q - round_q) : round_q);

  assign dp_state    = blk_q;
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign cipher_text = cipher_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign kexp_start  = kexp_start_q;
`ifdef AES_DECRYPT_EN
  assign dp_inv      = dec_q;
`endif

endmodule
